// File: rtl/proc_mem_pkg.sv
// Shared constants for the processor/memory arbiter: request types and owner tags.
package proc_mem_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  localparam logic OWNER_IMEM = 1'b0;
  localparam logic OWNER_DMEM = 1'b1;

endpackage

// File: rtl/arb_owner_fifo.sv
// Small synchronous FIFO of 1-bit owner tags; a push into a full FIFO is legal
// only when a pop happens in the same cycle.
module arb_owner_fifo #(
  parameter int p_depth = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int AW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CW = $clog2(p_depth + 1);

  logic [p_depth-1:0] mem;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               do_push;
  logic               do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(p_depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(p_depth));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop)
        rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/proc_mem_arbiter.sv
// Shares one memory port between fetch (imem) and data (dmem) requesters: dmem
// priority with an imem anti-starvation override, responses routed by owner FIFO.
module proc_mem_arbiter
  import proc_mem_pkg::*;
#(
  parameter int p_max_inflight = 2,
  parameter int p_max_dstreak  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic        dmemresp_val,
  output logic [31:0] dmemresp_data,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  output logic        memreq_type,
  output logic [31:0] memreq_addr,
  output logic [31:0] memreq_wdata,
  input  logic        memresp_val,
  input  logic [31:0] memresp_data
);

  localparam int SW = $clog2(p_max_dstreak + 1);

  logic [SW-1:0] dstreak;
  logic          force_imem;
  logic          gnt_dmem;
  logic          gnt_imem;
  logic          can_issue;
  logic          fire;
  logic          fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          resp_pop;

  assign force_imem = (dstreak == SW'(p_max_dstreak));
  assign gnt_dmem   = dmemreq_val & (~force_imem | ~imemreq_val);
  assign gnt_imem   = imemreq_val & ~gnt_dmem;

  // A response popping this cycle frees a slot, so a full FIFO can still issue.
  assign can_issue  = ~fifo_full | memresp_val;

  assign memreq_val   = (gnt_dmem | gnt_imem) & can_issue;
  assign memreq_type  = gnt_dmem ? dmemreq_type  : MEMREQ_READ;
  assign memreq_addr  = gnt_dmem ? dmemreq_addr  : (gnt_imem ? imemreq_addr : 32'h0);
  assign memreq_wdata = gnt_dmem ? dmemreq_wdata : 32'h0;

  assign dmemreq_rdy = gnt_dmem & memreq_rdy & can_issue;
  assign imemreq_rdy = gnt_imem & memreq_rdy & can_issue;
  assign fire        = memreq_val & memreq_rdy;

  arb_owner_fifo #(.p_depth(p_max_inflight)) u_owner_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fire),
    .push_data (gnt_dmem ? OWNER_DMEM : OWNER_IMEM),
    .pop       (memresp_val),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A response with nothing in flight has no owner and is dropped.
  assign resp_pop      = memresp_val & ~fifo_empty;
  assign imemresp_val  = resp_pop & (fifo_head == OWNER_IMEM);
  assign dmemresp_val  = resp_pop & (fifo_head == OWNER_DMEM);
  assign imemresp_data = imemresp_val ? memresp_data : 32'h0;
  assign dmemresp_data = dmemresp_val ? memresp_data : 32'h0;

  always_ff @(posedge clk) begin
    if (rst || !imemreq_val)
      dstreak <= '0;
    else if (fire && gnt_imem)
      dstreak <= '0;
    else if (fire && gnt_dmem && !force_imem)
      dstreak <= dstreak + 1'b1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(memresp_val && fifo_empty))
        else $warning("memory response arrived with no request in flight; dropped");
  end
`endif

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Directed self-checking bench for proc_mem_arbiter: reset, routing, contention,
// starvation override, full FIFO, backpressure and reset mid-operation.
module tb_proc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        dmemreq_val;
  logic        dmemreq_rdy;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic        dmemresp_val;
  logic [31:0] dmemresp_data;
  logic        memreq_val;
  logic        memreq_rdy;
  logic        memreq_type;
  logic [31:0] memreq_addr;
  logic [31:0] memreq_wdata;
  logic        memresp_val;
  logic [31:0] memresp_data;

  int num_checks = 0;
  int num_fails  = 0;

  always #5 clk = ~clk;

  proc_mem_arbiter #(.p_max_inflight(2), .p_max_dstreak(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .imemreq_val   (imemreq_val),
    .imemreq_rdy   (imemreq_rdy),
    .imemreq_addr  (imemreq_addr),
    .imemresp_val  (imemresp_val),
    .imemresp_data (imemresp_data),
    .dmemreq_val   (dmemreq_val),
    .dmemreq_rdy   (dmemreq_rdy),
    .dmemreq_type  (dmemreq_type),
    .dmemreq_addr  (dmemreq_addr),
    .dmemreq_wdata (dmemreq_wdata),
    .dmemresp_val  (dmemresp_val),
    .dmemresp_data (dmemresp_data),
    .memreq_val    (memreq_val),
    .memreq_rdy    (memreq_rdy),
    .memreq_type   (memreq_type),
    .memreq_addr   (memreq_addr),
    .memreq_wdata  (memreq_wdata),
    .memresp_val   (memresp_val),
    .memresp_data  (memresp_data)
  );

  task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                               input logic dv, input logic dt,
                               input logic [31:0] da, input logic [31:0] dw,
                               input logic mr, input logic rv,
                               input logic [31:0] rd);
    imemreq_val   = iv;
    imemreq_addr  = ia;
    dmemreq_val   = dv;
    dmemreq_type  = dt;
    dmemreq_addr  = da;
    dmemreq_wdata = dw;
    memreq_rdy    = mr;
    memresp_val   = rv;
    memresp_data  = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    assert (observed === expected)
      else begin
        num_fails++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  logic [9:0] dpat;

  initial begin
    dpat = 10'b0111101111;
    rst  = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Reset: everything quiet
    #3;
    checkOutput("rst_irdy", imemreq_rdy, 0);
    checkOutput("rst_drdy", dmemreq_rdy, 0);
    checkOutput("rst_mval", memreq_val, 0);
    checkOutput("rst_iresp", imemresp_val, 0);
    checkOutput("rst_dresp", dmemresp_val, 0);
    checkOutput("rst_maddr", memreq_addr, 0);
    tick();
    rst = 1'b0;

    // Stray response after reset is dropped
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h55); #3;
    checkOutput("drop_iresp", imemresp_val, 0);
    checkOutput("drop_dresp", dmemresp_val, 0);
    checkOutput("drop_ddata", dmemresp_data, 0);
    tick();

    // Single fetch
    applyStimulus(1, 32'h200, 0, 0, 0, 0, 1, 0, 0); #3;
    checkOutput("fetch_mval", memreq_val, 1);
    checkOutput("fetch_maddr", memreq_addr, 32'h200);
    checkOutput("fetch_mtype", memreq_type, 0);
    checkOutput("fetch_mwdata", memreq_wdata, 0);
    checkOutput("fetch_irdy", imemreq_rdy, 1);
    checkOutput("fetch_drdy", dmemreq_rdy, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h13); #3;
    checkOutput("fetch_iresp", imemresp_val, 1);
    checkOutput("fetch_idata", imemresp_data, 32'h13);
    checkOutput("fetch_dresp", dmemresp_val, 0);
    checkOutput("fetch_ddata", dmemresp_data, 0);
    checkOutput("fetch_mval2", memreq_val, 0);
    tick();

    // Contention: dmem store wins, then imem
    applyStimulus(1, 32'h204, 1, 1, 32'h100, 32'hDEADBEEF, 1, 0, 0); #3;
    checkOutput("cont_drdy", dmemreq_rdy, 1);
    checkOutput("cont_irdy", imemreq_rdy, 0);
    checkOutput("cont_mtype", memreq_type, 1);
    checkOutput("cont_maddr", memreq_addr, 32'h100);
    checkOutput("cont_mwdata", memreq_wdata, 32'hDEADBEEF);
    tick();
    applyStimulus(1, 32'h204, 0, 0, 0, 0, 1, 0, 0); #3;
    checkOutput("cont_irdy2", imemreq_rdy, 1);
    checkOutput("cont_maddr2", memreq_addr, 32'h204);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'hAAAA); #3;
    checkOutput("cont_dresp", dmemresp_val, 1);
    checkOutput("cont_ddata", dmemresp_data, 32'hAAAA);
    checkOutput("cont_iresp", imemresp_val, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h1234); #3;
    checkOutput("cont_iresp2", imemresp_val, 1);
    checkOutput("cont_idata2", imemresp_data, 32'h1234);
    checkOutput("cont_dresp2", dmemresp_val, 0);
    tick();

    // Starvation override: D,D,D,D,I,D,D,D,D,I
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 32'h208, 1, 0, 32'h300, 0, 1, (k != 0), 32'h1000 + k); #3;
      checkOutput("starve_drdy", dmemreq_rdy, dpat[k]);
      checkOutput("starve_irdy", imemreq_rdy, !dpat[k]);
      if (k > 0) begin
        checkOutput("starve_iresp", imemresp_val, !dpat[k-1]);
        checkOutput("starve_dresp", dmemresp_val, dpat[k-1]);
      end
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h2000); #3;
    checkOutput("starve_last_iresp", imemresp_val, 1);
    checkOutput("starve_last_idata", imemresp_data, 32'h2000);
    tick();

    // Full FIFO: two fires, stall, then pop+push in one cycle
    applyStimulus(1, 32'h20C, 1, 0, 32'h310, 0, 1, 0, 0); #3;
    checkOutput("full_drdy0", dmemreq_rdy, 1);
    tick(); #3;
    checkOutput("full_drdy1", dmemreq_rdy, 1);
    tick(); #3;
    checkOutput("full_mval", memreq_val, 0);
    checkOutput("full_drdy2", dmemreq_rdy, 0);
    checkOutput("full_irdy2", imemreq_rdy, 0);
    tick();
    applyStimulus(1, 32'h20C, 1, 0, 32'h310, 0, 1, 1, 32'h77); #3;
    checkOutput("full_pp_dresp", dmemresp_val, 1);
    checkOutput("full_pp_ddata", dmemresp_data, 32'h77);
    checkOutput("full_pp_iresp", imemresp_val, 0);
    checkOutput("full_pp_mval", memreq_val, 1);
    checkOutput("full_pp_drdy", dmemreq_rdy, 1);
    tick();
    applyStimulus(1, 32'h20C, 1, 0, 32'h310, 0, 1, 0, 0); #3;
    checkOutput("full_still_mval", memreq_val, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h01); #3;
    checkOutput("full_drain1", dmemresp_val, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h02); #3;
    checkOutput("full_drain2", dmemresp_val, 1);
    checkOutput("full_drain2_data", dmemresp_data, 32'h02);
    tick();

    // Backpressure: build streak to 3, stall 3 cycles, streak must hold
    applyStimulus(1, 32'h210, 1, 0, 32'h400, 0, 1, 0, 0); tick();
    applyStimulus(1, 32'h210, 1, 0, 32'h400, 0, 1, 1, 0); tick();
    applyStimulus(1, 32'h210, 1, 0, 32'h400, 0, 1, 1, 0); tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 32'h210, 1, 0, 32'h400, 0, 0, (k == 0), 32'h3000); #3;
      checkOutput("bp_mval", memreq_val, 1);
      checkOutput("bp_drdy", dmemreq_rdy, 0);
      checkOutput("bp_irdy", imemreq_rdy, 0);
      tick();
    end
    applyStimulus(1, 32'h210, 1, 0, 32'h400, 0, 1, 0, 0); #3;
    checkOutput("bp_rel_drdy", dmemreq_rdy, 1);
    checkOutput("bp_rel_irdy", imemreq_rdy, 0);
    tick();
    applyStimulus(1, 32'h210, 1, 0, 32'h400, 0, 1, 1, 32'h44); #3;
    checkOutput("bp_force_irdy", imemreq_rdy, 1);
    checkOutput("bp_force_drdy", dmemreq_rdy, 0);
    checkOutput("bp_force_dresp", dmemresp_val, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h55); #3;
    checkOutput("bp_drain_iresp", imemresp_val, 1);
    tick();

    // Reset mid-operation discards in-flight ownership
    applyStimulus(1, 32'h214, 0, 0, 0, 0, 1, 0, 0); #3;
    checkOutput("midrst_irdy", imemreq_rdy, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h66); #3;
    checkOutput("midrst_iresp", imemresp_val, 0);
    checkOutput("midrst_idata", imemresp_data, 0);
    tick();

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
